pingpong_fmap_buf: RTL and testbench

PINGPONG_FMAP_BUF -- requirements
Module: pingpong_fmap_buf

---
 rtl/pingpong_fmap_buf_pkg.sv | 17 +
 rtl/pingpong_fmap_buf_if.sv | 32 +++
 rtl/pingpong_fmap_buf_bank_ram.sv | 26 ++
 rtl/pingpong_fmap_buf.sv | 139 +++++++++++++
 tb/tb_pingpong_fmap_buf.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/pingpong_fmap_buf_pkg.sv
// Shared types and defaults for the ping-pong feature-map buffer.
// Defines the bank-state encoding and the default geometry used by the buffer, its interface and its RAMs.
package pingpong_fmap_buf_pkg;

    localparam int DEF_DW    = 16;
    localparam int DEF_CH    = 64;
    localparam int DEF_DEPTH = 3025;
    localparam int DEF_AW    = 12;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2,
        BANK_READING = 2'd3
    } bank_state_t;

endpackage

// File: rtl/pingpong_fmap_buf_if.sv
// Producer/consumer bus of the ping-pong feature-map buffer.
// The master modport is the accelerator side; the slave modport is the buffer.
interface pingpong_fmap_buf_if
    import pingpong_fmap_buf_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int CH = DEF_CH,
    parameter int AW = DEF_AW
);
    logic [AW-1:0]    inputsize;
    logic             wr_valid;
    logic [CH*DW-1:0] wr_data;
    logic             wr_ready;
    logic             wr_frame_done;
    logic             rd_avail;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [CH*DW-1:0] rd_data;
    logic             rd_valid;
    logic             rd_release;
    logic             cfg_err;

    modport master (
        output inputsize, wr_valid, wr_data, rd_en, rd_addr, rd_release,
        input  wr_ready, wr_frame_done, rd_avail, rd_data, rd_valid, cfg_err
    );

    modport slave (
        input  inputsize, wr_valid, wr_data, rd_en, rd_addr, rd_release,
        output wr_ready, wr_frame_done, rd_avail, rd_data, rd_valid, cfg_err
    );
endinterface

// File: rtl/pingpong_fmap_buf_bank_ram.sv
// One feature-map bank: single write port and a registered read port.
// The read register is not reset; the buffer gates its output with its own valid flag.
module fmap_bank_ram #(
    parameter int W     = 1024,
    parameter int DEPTH = 3025,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/pingpong_fmap_buf.sv
// Two-bank ping-pong buffer: the producer fills one bank while the consumer reads the other.
// Each bank remembers its own frame length so consecutive frames may differ in size.
module pingpong_fmap_buf
    import pingpong_fmap_buf_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int CH    = DEF_CH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW
) (
    input  logic               clk,
    input  logic               rst,
    pingpong_fmap_buf_if.slave bus
);
    localparam int W = CH * DW;

    bank_state_t   bank_state [2];
    bank_state_t   state_nxt  [2];
    logic [AW-1:0] frame_len  [2];
    logic [AW-1:0] len_nxt    [2];
    logic [AW-1:0] wr_ptr, wr_ptr_nxt;
    logic          wr_sel, wr_sel_nxt;
    logic          rd_sel, rd_sel_nxt;
    logic          cfg_err, cfg_err_nxt;
    logic          frame_done;
    logic          done_nxt;
    logic          rd_valid_q;
    logic          rd_pad_q;
    logic          rd_bank_q;
    logic [W-1:0]  ram_q [2];

    bank_state_t   wr_state, rd_state;
    logic [AW-1:0] eff_len;
    logic          size_ok, wr_ready, wr_fire, wr_last;
    logic          rd_avail, rd_fire, rd_pad;

    assign wr_state = bank_state[wr_sel];
    assign rd_state = bank_state[rd_sel];
    assign size_ok  = (bus.inputsize != '0) && (int'(bus.inputsize) <= DEPTH);
    assign wr_ready = !rst && !cfg_err &&
                      ((wr_state == BANK_FILLING) || ((wr_state == BANK_EMPTY) && size_ok));
    assign wr_fire  = bus.wr_valid && wr_ready;
    // A bank that is still EMPTY takes its length from the live inputsize on its first word.
    assign eff_len  = (wr_state == BANK_EMPTY) ? bus.inputsize : frame_len[wr_sel];
    assign wr_last  = (wr_ptr == eff_len - AW'(1));

    assign rd_avail = (rd_state == BANK_FULL) || (rd_state == BANK_READING);
    assign rd_fire  = bus.rd_en && rd_avail;
    assign rd_pad   = (bus.rd_addr >= frame_len[rd_sel]);

    always_comb begin
        state_nxt   = bank_state;
        len_nxt     = frame_len;
        wr_ptr_nxt  = wr_ptr;
        wr_sel_nxt  = wr_sel;
        rd_sel_nxt  = rd_sel;
        cfg_err_nxt = cfg_err;
        done_nxt    = 1'b0;

        if (!cfg_err && (wr_state == BANK_EMPTY) && bus.wr_valid && !size_ok) begin
            cfg_err_nxt = 1'b1;
        end

        if (wr_fire) begin
            if (wr_state == BANK_EMPTY) begin
                len_nxt[wr_sel]   = bus.inputsize;
                state_nxt[wr_sel] = BANK_FILLING;
            end
            if (wr_last) begin
                state_nxt[wr_sel] = BANK_FULL;
                wr_ptr_nxt        = '0;
                wr_sel_nxt        = ~wr_sel;
                done_nxt          = 1'b1;
            end else begin
                wr_ptr_nxt = wr_ptr + AW'(1);
            end
        end

        // The write bank is EMPTY/FILLING and the read bank FULL/READING, so these never collide.
        if (bus.rd_release && rd_avail) begin
            state_nxt[rd_sel] = BANK_EMPTY;
            rd_sel_nxt        = ~rd_sel;
        end else if (rd_fire && (rd_state == BANK_FULL)) begin
            state_nxt[rd_sel] = BANK_READING;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                bank_state[b] <= BANK_EMPTY;
                frame_len[b]  <= '0;
            end
            wr_ptr     <= '0;
            wr_sel     <= 1'b0;
            rd_sel     <= 1'b0;
            cfg_err    <= 1'b0;
            frame_done <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_pad_q   <= 1'b0;
            rd_bank_q  <= 1'b0;
        end else begin
            bank_state <= state_nxt;
            frame_len  <= len_nxt;
            wr_ptr     <= wr_ptr_nxt;
            wr_sel     <= wr_sel_nxt;
            rd_sel     <= rd_sel_nxt;
            cfg_err    <= cfg_err_nxt;
            frame_done <= done_nxt;
            rd_valid_q <= rd_fire;
            rd_pad_q   <= rd_pad;
            rd_bank_q  <= rd_sel;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fmap_bank_ram #(
            .W     (W),
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_ram (
            .clk   (clk),
            .we    (wr_fire && (wr_sel == 1'(b))),
            .waddr (wr_ptr),
            .wdata (bus.wr_data),
            .re    (rd_fire && !rd_pad && (rd_sel == 1'(b))),
            .raddr (bus.rd_addr),
            .rdata (ram_q[b])
        );
    end

    // Addresses past the frame end read back as zero so pooling borders need no special casing.
    assign bus.rd_data       = (rd_valid_q && !rd_pad_q) ? ram_q[rd_bank_q] : '0;
    assign bus.rd_valid      = rd_valid_q;
    assign bus.wr_ready      = wr_ready;
    assign bus.wr_frame_done = frame_done;
    assign bus.rd_avail      = rd_avail;
    assign bus.cfg_err       = cfg_err;
endmodule

// File: tb/tb_pingpong_fmap_buf.sv
// Directed bench for the ping-pong buffer with hand-computed expected words.
// Small geometry (4 channels x 16 bits, 16-pixel banks) keeps the frames readable.
module tb_pingpong_fmap_buf;
    localparam int TDW    = 16;
    localparam int TCH    = 4;
    localparam int TDEPTH = 16;
    localparam int TAW    = 4;

    logic clk;
    logic rst;
    int   compare_count;
    int   fail_count;

    pingpong_fmap_buf_if #(.DW(TDW), .CH(TCH), .AW(TAW)) bus ();

    pingpong_fmap_buf #(
        .DW    (TDW),
        .CH    (TCH),
        .DEPTH (TDEPTH),
        .AW    (TAW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        compare_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Offers one word and waits (bounded) until the buffer accepts it.
    task automatic applyStimulus(input logic [63:0] data);
        int n;
        n = 0;
        bus.wr_valid = 1'b1;
        bus.wr_data  = data;
        #1;
        while (!bus.wr_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            checkOutput("wr_ready_timeout", 64'(bus.wr_ready), 64'd1);
        end else begin
            tick();
        end
        bus.wr_valid = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [TAW-1:0] addr, input logic [63:0] exp);
        bus.rd_en   = 1'b1;
        bus.rd_addr = addr;
        tick();
        bus.rd_en = 1'b0;
        #1;
        checkOutput({tag, "_valid"}, 64'(bus.rd_valid), 64'd1);
        checkOutput({tag, "_data"}, bus.rd_data, exp);
    endtask

    task automatic release_bank();
        bus.rd_release = 1'b1;
        tick();
        bus.rd_release = 1'b0;
        #1;
    endtask

    initial begin
        compare_count  = 0;
        fail_count     = 0;
        rst            = 1'b1;
        bus.inputsize  = '0;
        bus.wr_valid   = 1'b0;
        bus.wr_data    = '0;
        bus.rd_en      = 1'b0;
        bus.rd_addr    = '0;
        bus.rd_release = 1'b0;
        tick();
        tick();
        checkOutput("rst_wr_ready", 64'(bus.wr_ready), 64'd0);
        checkOutput("rst_done", 64'(bus.wr_frame_done), 64'd0);
        checkOutput("rst_rd_avail", 64'(bus.rd_avail), 64'd0);
        checkOutput("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
        checkOutput("rst_rd_data", bus.rd_data, 64'd0);
        checkOutput("rst_cfg_err", 64'(bus.cfg_err), 64'd0);
        rst = 1'b0;
        bus.inputsize = 4'd4;

        $display("[TB] basic fill into bank0");
        for (int i = 1; i <= 4; i++) applyStimulus(64'(i));
        checkOutput("fill_done_pulse", 64'(bus.wr_frame_done), 64'd1);
        checkOutput("fill_rd_avail", 64'(bus.rd_avail), 64'd1);
        tick();
        checkOutput("fill_done_single", 64'(bus.wr_frame_done), 64'd0);
        for (int i = 0; i < 4; i++) read_check("fill_rd", 4'(i), 64'(i + 1));

        $display("[TB] stall with both banks occupied");
        for (int i = 0; i < 4; i++) applyStimulus(64'h11 + 64'(i));
        #1;
        checkOutput("stall_wr_ready", 64'(bus.wr_ready), 64'd0);
        release_bank();
        checkOutput("stall_wr_ready_after_rel", 64'(bus.wr_ready), 64'd1);
        checkOutput("stall_rd_avail_bank1", 64'(bus.rd_avail), 64'd1);

        $display("[TB] overlap: stream into bank0 while reading bank1");
        for (int i = 0; i < 4; i++) begin
            bus.wr_valid   = 1'b1;
            bus.wr_data    = 64'h21 + 64'(i);
            bus.rd_en      = 1'b1;
            bus.rd_addr    = 4'(i);
            bus.rd_release = (i == 3);
            tick();
            bus.wr_valid   = 1'b0;
            bus.rd_en      = 1'b0;
            bus.rd_release = 1'b0;
            #1;
            checkOutput("ovl_rd_data", bus.rd_data, 64'h11 + 64'(i));
        end
        checkOutput("ovl_done", 64'(bus.wr_frame_done), 64'd1);
        checkOutput("ovl_rd_avail_bank0", 64'(bus.rd_avail), 64'd1);
        checkOutput("ovl_wr_ready_bank1", 64'(bus.wr_ready), 64'd1);
        read_check("ovl_b0_a0", 4'd0, 64'h21);
        read_check("ovl_b0_a3", 4'd3, 64'h24);
        release_bank();
        checkOutput("empty_rd_avail", 64'(bus.rd_avail), 64'd0);

        $display("[TB] ignored read and release while nothing is available");
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        #1;
        checkOutput("noavail_rd_valid", 64'(bus.rd_valid), 64'd0);
        release_bank();

        $display("[TB] variable frame sizes 3 then 5");
        bus.inputsize = 4'd3;
        for (int i = 0; i < 3; i++) applyStimulus(64'h31 + 64'(i));
        bus.inputsize = 4'd5;
        for (int i = 0; i < 5; i++) applyStimulus(64'h41 + 64'(i));
        read_check("varA_a2", 4'd2, 64'h33);
        read_check("varA_a4_pad", 4'd4, 64'd0);
        read_check("varA_a5_pad", 4'd5, 64'd0);
        release_bank();
        read_check("varB_a0", 4'd0, 64'h41);
        read_check("varB_a4", 4'd4, 64'h45);
        release_bank();

        $display("[TB] reset in the middle of a frame");
        bus.inputsize = 4'd4;
        applyStimulus(64'h99);
        applyStimulus(64'h9A);
        rst = 1'b1;
        tick();
        checkOutput("mid_rst_wr_ready", 64'(bus.wr_ready), 64'd0);
        checkOutput("mid_rst_rd_avail", 64'(bus.rd_avail), 64'd0);
        checkOutput("mid_rst_done", 64'(bus.wr_frame_done), 64'd0);
        checkOutput("mid_rst_rd_valid", 64'(bus.rd_valid), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(64'h51 + 64'(i));
        checkOutput("post_rst_done", 64'(bus.wr_frame_done), 64'd1);
        read_check("post_rst_a0", 4'd0, 64'h51);
        read_check("post_rst_a3", 4'd3, 64'h54);
        release_bank();

        $display("[TB] illegal inputsize");
        bus.inputsize = 4'd0;
        bus.wr_valid  = 1'b1;
        bus.wr_data   = 64'h77;
        #1;
        checkOutput("cfg_wr_ready_zero", 64'(bus.wr_ready), 64'd0);
        tick();
        checkOutput("cfg_err_set", 64'(bus.cfg_err), 64'd1);
        bus.inputsize = 4'd4;
        tick();
        checkOutput("cfg_err_sticky", 64'(bus.cfg_err), 64'd1);
        checkOutput("cfg_wr_ready_held", 64'(bus.wr_ready), 64'd0);
        bus.wr_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checkOutput("cfg_err_cleared", 64'(bus.cfg_err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end
endmodule
